// File: rtl/mem_arbiter.sv
// Byte-wide memory bus arbiter: grants fetch, load and store requests,
// serialises each 1/2/4-byte access into byte cycles, aborts speculative
// reads on a branch flush and lets committed stores run to completion.
module mem_arbiter #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              has_misbranch,
   input  logic              io_buffer_full,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [2:0]        ld_len,
   output logic              ld_done,
   output logic [31:0]       ld_data,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [2:0]        st_len,
   input  logic [31:0]       st_data,
   output logic              st_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base;
   logic [2:0]        len;
   logic [2:0]        cnt;        // bytes completed (sampled or written)
   logic [2:0]        issued;     // read addresses presented so far
   logic              addr_live;  // address on the bus this cycle is a fresh read
   logic              data_due;   // ram_din this cycle answers a fresh read
   logic              is_fetch;
   logic              rr_load;    // round-robin pointer: 0 = fetch next, 1 = load next
   logic [31:0]       st_word;
   logic [31:0]       asm_data;
   logic [31:0]       filled;
   logic [2:0]        cnt_nxt;
   logic              io_stall;
   logic              st_ok, if_ok, ld_ok;
   logic              grant_if, grant_ld;

   function automatic logic [2:0] len_of(input logic [2:0] l);
      case (l)
         3'd1:    return 3'd1;
         3'd2:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
      return w[{i, 3'b000} +: 8];
   endfunction

   // Request qualification, grant selection and byte assembly
   always_comb begin
      cnt_nxt  = cnt + 3'd1;
      io_stall = (base[17:16] == IO_SEL) && io_buffer_full;
      ram_wr   = (state == S_WRITE) && rdy && !io_stall;
      // A requester is never re-granted in the cycle its done pulses
      st_ok    = st_req && !st_done;
      if_ok    = if_req && !if_done;
      ld_ok    = ld_req && !ld_done;
      grant_if = !st_ok && if_ok && (!ld_ok || !rr_load);
      grant_ld = !st_ok && ld_ok && !grant_if;
      filled   = asm_data;
      filled[{cnt[1:0], 3'b000} +: 8] = ram_din;
   end

   // Arbitration FSM, byte sequencing and done/data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         base      <= '0;
         len       <= 3'd0;
         cnt       <= 3'd0;
         issued    <= 3'd0;
         addr_live <= 1'b0;
         data_due  <= 1'b0;
         is_fetch  <= 1'b0;
         rr_load   <= 1'b0;
         st_word   <= 32'd0;
         asm_data  <= 32'd0;
         ram_addr  <= '0;
         ram_dout  <= 8'd0;
         if_done   <= 1'b0;
         if_data   <= 32'd0;
         ld_done   <= 1'b0;
         ld_data   <= 32'd0;
         st_done   <= 1'b0;
      end else begin
         if_done <= 1'b0;
         ld_done <= 1'b0;
         st_done <= 1'b0;
         if (rdy) begin
            case (state)
               S_IDLE: begin
                  if (!has_misbranch) begin
                     if (st_ok) begin
                        state    <= S_WRITE;
                        base     <= st_addr;
                        len      <= len_of(st_len);
                        cnt      <= 3'd0;
                        st_word  <= st_data;
                        ram_addr <= st_addr;
                        ram_dout <= st_data[7:0];
                     end else if (grant_if || grant_ld) begin
                        state     <= S_READ;
                        base      <= grant_if ? if_addr : ld_addr;
                        len       <= grant_if ? 3'd4 : len_of(ld_len);
                        ram_addr  <= grant_if ? if_addr : ld_addr;
                        is_fetch  <= grant_if;
                        rr_load   <= grant_if;
                        cnt       <= 3'd0;
                        issued    <= 3'd1;
                        addr_live <= 1'b1;
                        data_due  <= 1'b0;
                        asm_data  <= 32'd0;
                     end
                  end
               end
               S_READ: begin
                  if (has_misbranch) begin
                     state     <= S_IDLE;
                     addr_live <= 1'b0;
                     data_due  <= 1'b0;
                  end else begin
                     data_due <= addr_live;
                     if (issued < len) begin
                        ram_addr  <= base + ADDR_W'(issued);
                        issued    <= issued + 3'd1;
                        addr_live <= 1'b1;
                     end else begin
                        addr_live <= 1'b0;
                     end
                     if (data_due) begin
                        asm_data <= filled;
                        cnt      <= cnt_nxt;
                        if (cnt_nxt == len) begin
                           state     <= S_IDLE;
                           addr_live <= 1'b0;
                           data_due  <= 1'b0;
                           if (is_fetch) begin
                              if_done <= 1'b1;
                              if_data <= filled;
                           end else begin
                              ld_done <= 1'b1;
                              ld_data <= filled;
                           end
                        end
                     end
                  end
               end
               S_WRITE: begin
                  if (!io_stall) begin
                     if (cnt_nxt == len) begin
                        state   <= S_IDLE;
                        st_done <= 1'b1;
                     end else begin
                        cnt      <= cnt_nxt;
                        ram_addr <= base + ADDR_W'(cnt_nxt);
                        ram_dout <= byte_of(st_word, cnt_nxt[1:0]);
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else if (state == S_READ) begin
            // Paused: the RAM keeps reading the held address. If that address is
            // the next unsampled byte, take it on resume; otherwise rewind so the
            // next unsampled byte's address is presented again.
            addr_live <= 1'b0;
            if (issued == cnt_nxt) begin
               data_due <= 1'b1;
            end else begin
               data_due <= 1'b0;
               issued   <= cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        has_misbranch = 1'b0;
   logic        io_buffer_full = 1'b0;
   logic [7:0]  ram_din = 8'd0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_done;
   logic [31:0] if_data;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [2:0]  ld_len = 3'd0;
   logic        ld_done;
   logic [31:0] ld_data;
   logic        st_req = 1'b0;
   logic [31:0] st_addr = 32'd0;
   logic [2:0]  st_len = 3'd0;
   logic [31:0] st_data = 32'd0;
   logic        st_done;

   logic [7:0]  mem [0:1023];
   logic [7:0]  io_last = 8'd0;
   int          io_cnt = 0;
   int          compared = 0;
   int          mismatched = 0;

   mem_arbiter #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
      .io_buffer_full(io_buffer_full), .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_addr(ram_addr), .ram_wr(ram_wr),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
      .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after its address; IO region writes are logged
   always @(posedge clk) begin
      if (ram_wr) begin
         if (ram_addr[17:16] == 2'b11) begin
            io_last <= ram_dout;
            io_cnt  <= io_cnt + 1;
         end else begin
            mem[ram_addr[9:0]] <= ram_dout;
         end
      end
      ram_din <= mem[ram_addr[9:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Tick until the chosen done pulses (0 fetch, 1 load, 2 store); compare the tick count
   task automatic wait_done(input int which, input int exp, input string tag);
      int  n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         tick();
         n++;
         case (which)
            0:       seen = if_done;
            1:       seen = ld_done;
            default: seen = st_done;
         endcase
      end
      chk(tag, n, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h100] = 8'h13; mem[10'h101] = 8'h05; mem[10'h102] = 8'h00; mem[10'h103] = 8'h00;
      mem[10'h104] = 8'h93; mem[10'h105] = 8'h00; mem[10'h106] = 8'h10; mem[10'h107] = 8'h00;
      mem[10'h200] = 8'h37; mem[10'h201] = 8'h41; mem[10'h202] = 8'h00; mem[10'h203] = 8'h00;
      mem[10'h080] = 8'h34; mem[10'h081] = 8'h12;

      // Reset state
      rst = 1'b0;
      tick();
      tick();
      chk("rst_ram_wr", ram_wr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_dout", ram_dout, 0);
      chk("rst_dones", {if_done, ld_done, st_done}, 0);
      chk("rst_if_data", if_data, 0);
      chk("rst_ld_data", ld_data, 0);
      rst = 1'b1;

      // Fetch at 0x100
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      chk("t1_addr0", ram_addr, 32'h100);
      chk("t1_wr", ram_wr, 0);
      wait_done(0, 5, "t1_latency");
      chk("t1_data", if_data, 32'h0000_0513);
      if_req = 1'b0;

      // Fetch and load together after reset: fetch first, then load, then fetch again
      do_reset();
      if_req = 1'b1; if_addr = 32'h104;
      ld_req = 1'b1; ld_addr = 32'h80; ld_len = 3'd1;
      tick();
      chk("t2_fetch_first", ram_addr, 32'h104);
      wait_done(0, 5, "t2_fetch_lat");
      chk("t2_fetch_data", if_data, 32'h0010_0093);
      if_req = 1'b0;
      wait_done(1, 3, "t2_load_lat");
      chk("t2_load_data", ld_data, 32'h0000_0034);
      ld_req = 1'b0;
      tick();
      if_req = 1'b1; if_addr = 32'h100;
      ld_req = 1'b1;
      tick();
      chk("t2_rr_fetch", ram_addr, 32'h100);
      ld_req = 1'b0;
      wait_done(0, 5, "t2_fetch2_lat");
      chk("t2_fetch2_data", if_data, 32'h0000_0513);
      if_req = 1'b0;
      tick();

      // IO store stalled by a full buffer for 3 cycles
      io_buffer_full = 1'b1;
      st_req = 1'b1; st_addr = 32'h30000; st_len = 3'd1; st_data = 32'h41;
      tick();
      chk("t3_addr", ram_addr, 32'h30000);
      chk("t3_stall0", ram_wr, 0);
      tick();
      chk("t3_stall1", ram_wr, 0);
      tick();
      chk("t3_stall2", ram_wr, 0);
      tick();
      io_buffer_full = 1'b0;
      #1;
      chk("t3_wr", ram_wr, 1);
      chk("t3_dout", ram_dout, 32'h41);
      tick();
      chk("t3_done", st_done, 1);
      chk("t3_io_cnt", io_cnt, 1);
      chk("t3_io_byte", io_last, 32'h41);
      st_req = 1'b0;
      tick();

      // Fetch aborted by a misbranch after two bytes, then a clean fetch at 0x200
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      tick();
      tick();
      tick();
      has_misbranch = 1'b1;
      if_req = 1'b0;
      tick();
      has_misbranch = 1'b0;
      chk("t4_no_done0", if_done, 0);
      tick();
      chk("t4_no_done1", if_done, 0);
      tick();
      chk("t4_no_done2", if_done, 0);
      if_req = 1'b1; if_addr = 32'h200;
      wait_done(0, 6, "t4_latency");
      chk("t4_data", if_data, 32'h0000_4137);
      if_req = 1'b0;
      tick();

      // Word store at 0x1FC with a misbranch mid-write
      st_req = 1'b1; st_addr = 32'h1FC; st_len = 3'd4; st_data = 32'hDEAD_BEEF;
      tick();
      chk("t5_wr0", ram_wr, 1);
      chk("t5_dout0", ram_dout, 32'hEF);
      tick();
      has_misbranch = 1'b1;
      tick();
      has_misbranch = 1'b0;
      wait_done(2, 2, "t5_latency");
      st_req = 1'b0;
      chk("t5_mem", {mem[10'h1FF], mem[10'h1FE], mem[10'h1FD], mem[10'h1FC]}, 32'hDEAD_BEEF);
      tick();

      // Half-word load with rdy low for the first two cycles
      ld_req = 1'b1; ld_addr = 32'h80; ld_len = 3'd2;
      tick();
      rdy = 1'b0;
      chk("t6_addr0", ram_addr, 32'h80);
      tick();
      chk("t6_hold", ram_addr, 32'h80);
      chk("t6_wr", ram_wr, 0);
      tick();
      rdy = 1'b1;
      wait_done(1, 3, "t6_latency");
      chk("t6_data", ld_data, 32'h0000_1234);
      ld_req = 1'b0;
      tick();

      // Load length 3 is treated as a 4-byte access
      ld_req = 1'b1; ld_addr = 32'h100; ld_len = 3'd3;
      wait_done(1, 6, "t7_latency");
      chk("t7_data", ld_data, 32'h0000_0513);
      ld_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
